// File: rtl/synth_pipeline.sv
// One DDS voice: held MIDI note -> 32-bit phase accumulator -> quarter-wave sine lookup.
// Three-stage output pipeline (address/quadrant, ROM read, conditional negate).
module synth_pipeline (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] i_data,
  output logic [1:0]  o_state,
  output logic [15:0] o_signal
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BSY  = 2'b01,
    RDY  = 2'b10
  } state_t;

  // round(32767 * sin(pi*idx/512)), evaluated at elaboration with a Q30 Taylor series.
  function automatic logic [14:0] sine_entry(input int idx);
    longint x, x2, term, acc;
    x    = (longint'(idx) * 64'sd3373259426) / 64'sd512;
    x2   = (x * x) >>> 30;
    term = x;
    acc  = x;
    for (int n = 3; n <= 17; n += 2) begin
      term = -((term * x2) >>> 30) / longint'((n - 1) * n);
      acc  = acc + term;
    end
    return 15'((acc * 64'sd32767 + 64'sd536870912) >>> 30);
  endfunction

  function automatic logic [31:0] note_inc(input logic [6:0] note);
    logic [31:0] base;
    logic [6:0]  oct;
    oct = note / 7'd12;
    case (note % 7'd12)
      7'd0:    base = 32'd719151;
      7'd1:    base = 32'd761914;
      7'd2:    base = 32'd807220;
      7'd3:    base = 32'd855219;
      7'd4:    base = 32'd906073;
      7'd5:    base = 32'd959951;
      7'd6:    base = 32'd1017033;
      7'd7:    base = 32'd1077508;
      7'd8:    base = 32'd1141581;
      7'd9:    base = 32'd1209463;
      7'd10:   base = 32'd1281381;
      default: base = 32'd1357576;
    endcase
    return base >> (7'd10 - oct);
  endfunction

  logic [14:0] rom [256];

  for (genvar gi = 0; gi < 256; gi++) begin : g_rom
    localparam logic [14:0] ENTRY = sine_entry(gi);
    assign rom[gi] = ENTRY;
  end

  logic       cmd;
  logic [6:0] note;
  logic       unused_bits;
  assign cmd         = i_data[15];
  assign note        = i_data[14:8];
  assign unused_bits = ^i_data[7:0];

  state_t      state_reg, state_next;
  logic [1:0]  cnt_reg, cnt_next;
  logic [6:0]  note_reg, note_next;
  logic [31:0] inc_reg, inc_next;
  logic [31:0] phase_reg, phase_next;
  logic        run, clear;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    note_next  = note_reg;
    inc_next   = inc_reg;
    phase_next = phase_reg + inc_reg;
    run        = 1'b0;
    clear      = 1'b0;
    case (state_reg)
      IDLE: begin
        phase_next = 32'd0;
        clear      = 1'b1;
        if (cmd && note != 7'd0) begin
          state_next = BSY;
          cnt_next   = 2'd0;
          note_next  = note;
          inc_next   = note_inc(note);
        end
      end
      BSY, RDY: begin
        if (!cmd) begin
          state_next = IDLE;
          note_next  = 7'd0;
          phase_next = 32'd0;
          clear      = 1'b1;
        end else if (note != 7'd0 && note != note_reg) begin
          // Retrigger: restart from phase 0 and flush every in-flight sample.
          state_next = BSY;
          cnt_next   = 2'd0;
          note_next  = note;
          inc_next   = note_inc(note);
          phase_next = 32'd0;
          clear      = 1'b1;
        end else begin
          run = 1'b1;
          if (state_reg == BSY) begin
            if (cnt_reg == 2'd2) state_next = RDY;
            else                 cnt_next   = cnt_reg + 2'd1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        phase_next = 32'd0;
        clear      = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 2'd0;
      note_reg  <= 7'd0;
      inc_reg   <= 32'd0;
      phase_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      note_reg  <= note_next;
      inc_reg   <= inc_next;
      phase_reg <= phase_next;
    end
  end

  logic [1:0]  s1_quad_reg, s2_quad_reg;
  logic [7:0]  s1_addr_reg;
  logic [14:0] s2_data_reg;
  logic        s1_valid_reg, s2_valid_reg;
  logic [15:0] signal_reg;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      s1_quad_reg  <= 2'd0;
      s1_addr_reg  <= 8'd0;
      s1_valid_reg <= 1'b0;
      s2_quad_reg  <= 2'd0;
      s2_data_reg  <= 15'd0;
      s2_valid_reg <= 1'b0;
      signal_reg   <= 16'd0;
    end else if (run) begin
      s1_quad_reg  <= phase_reg[31:30];
      // Odd quadrants walk the quarter wave backwards: 255-i is just ~i.
      s1_addr_reg  <= phase_reg[30] ? ~phase_reg[29:22] : phase_reg[29:22];
      s1_valid_reg <= 1'b1;
      s2_quad_reg  <= s1_quad_reg;
      s2_data_reg  <= rom[s1_addr_reg];
      s2_valid_reg <= s1_valid_reg;
      if (!s2_valid_reg)      signal_reg <= 16'd0;
      else if (s2_quad_reg[1]) signal_reg <= 16'd0 - {1'b0, s2_data_reg};
      else                     signal_reg <= {1'b0, s2_data_reg};
    end
  end

  assign o_state  = state_reg;
  assign o_signal = signal_reg;

endmodule

// File: tb/tb_synth_pipeline.sv
// Bench for synth_pipeline: a cycle-level behavioural voice model checked every clock,
// plus literal checks of start latency, sine values, retrigger, stop and reset.
module tb_synth_pipeline;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] i_data = 16'h0000;
  logic [1:0]  o_state;
  logic [15:0] o_signal;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;
  int tq [256];

  always #5 clk = ~clk;

  synth_pipeline dut (
    .clk     (clk),
    .rst     (rst),
    .i_data  (i_data),
    .o_state (o_state),
    .o_signal(o_signal)
  );

  initial begin
    for (int i = 0; i < 256; i++) begin
      real v;
      v = 32767.0 * $sin(2.0 * 3.14159265358979323846 * real'(i) / 1024.0);
      tq[i] = $rtoi(v + 0.5);
    end
  end

  function automatic longint inc_of(int n);
    longint base [12];
    base = '{719151, 761914, 807220, 855219, 906073, 959951,
             1017033, 1077508, 1141581, 1209463, 1281381, 1357576};
    return base[n % 12] >> (10 - n / 12);
  endfunction

  function automatic int exp_sample(int k, int n);
    logic [31:0] ph;
    int q, i, v;
    ph = 32'(longint'(k) * inc_of(n));
    q  = int'(ph[31:30]);
    i  = int'(ph[29:22]);
    v  = (q % 2 == 1) ? tq[255 - i] : tq[i];
    return (q >= 2) ? -v : v;
  endfunction

  // Model: idle, or running with m_t edges elapsed since the accepting edge.
  bit m_run = 1'b0;
  int m_t = 0;
  int m_note = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_run <= 1'b0; m_t <= 0; m_note <= 0;
    end else if (!m_run) begin
      if (i_data[15] && i_data[14:8] != 7'd0) begin
        m_run <= 1'b1; m_t <= 0; m_note <= int'(i_data[14:8]);
      end
    end else if (!i_data[15]) begin
      m_run <= 1'b0;
    end else if (i_data[14:8] != 7'd0 && int'(i_data[14:8]) != m_note) begin
      m_t <= 0; m_note <= int'(i_data[14:8]);
    end else begin
      m_t <= m_t + 1;
    end
  end

  always @(posedge clk) begin
    logic [1:0]  es;
    logic [15:0] ev;
    #1;
    if (chk_en) begin
      if (!m_run)       begin es = 2'b00; ev = 16'd0; end
      else if (m_t < 3) begin es = 2'b01; ev = 16'd0; end
      else              begin es = 2'b10; ev = 16'(exp_sample(m_t - 3, m_note)); end
      tests++;
      if (o_state !== es || o_signal !== ev) begin
        fails++;
        $display("FAIL model t=%0t: state=%b sig=%0d, expected state=%b sig=%0d",
                 $time, o_state, $signed(o_signal), es, $signed(ev));
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)", name, got, got, exp, exp);
    end
  endtask

  task automatic edge_chk();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int len;
    logic [6:0] rnote;
    // Reset with i_data = 0
    edge_chk();
    chk("reset_state", 16'(o_state), 16'd0);
    chk("reset_signal", o_signal, 16'd0);
    chk_en = 1'b1;
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_hold_state", 16'(o_state), 16'd0);

    // Start note 127 and check pipeline latency
    i_data = 16'hFF00;
    @(posedge clk);                                   // E0
    edge_chk(); chk("start_e1_state", 16'(o_state), 16'd1);
    edge_chk(); chk("start_e2_state", 16'(o_state), 16'd1);
    edge_chk(); chk("start_e3_state", 16'(o_state), 16'd2);
    chk("start_e3_signal", o_signal, 16'd0);
    repeat (3) @(posedge clk);
    edge_chk(); chk("k4_signal", o_signal, 16'd201);
    repeat (992) @(posedge clk);
    edge_chk(); chk("k997_q1_peak", o_signal, 16'd32766);
    repeat (1102) @(posedge clk);
    edge_chk(); chk("k2100_q2_negative", 16'(o_signal[15]), 16'd1);

    // Retrigger to note 69
    @(negedge clk) i_data = 16'hC500;
    edge_chk(); chk("retrig_er_state", 16'(o_state), 16'd1);
    chk("retrig_er_signal", o_signal, 16'd0);
    edge_chk(); chk("retrig_e1_state", 16'(o_state), 16'd1);
    edge_chk(); chk("retrig_e2_state", 16'(o_state), 16'd1);
    chk("retrig_e2_signal", o_signal, 16'd0);
    edge_chk(); chk("retrig_e3_state", 16'(o_state), 16'd2);
    chk("retrig_e3_signal", o_signal, 16'd0);
    repeat (3000) @(posedge clk);

    // Stop, then an invalid start with note 0
    @(negedge clk) i_data = 16'h0000;
    edge_chk(); chk("stop_state", 16'(o_state), 16'd0);
    chk("stop_signal", o_signal, 16'd0);
    @(negedge clk) i_data = 16'h8000;
    repeat (4) @(posedge clk);
    edge_chk(); chk("note0_state", 16'(o_state), 16'd0);

    // Stop followed by restart on the very next edge
    @(negedge clk) i_data = 16'hFF00;
    repeat (20) @(negedge clk);
    i_data = 16'h0000;
    @(negedge clk) i_data = 16'hFF00;
    repeat (10) @(negedge clk);

    // Reset pulse while RDY, start still held
    rst = 1'b1;
    edge_chk(); chk("rst_run_state", 16'(o_state), 16'd0);
    chk("rst_run_signal", o_signal, 16'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);                                   // start accepted here
    repeat (2) @(posedge clk);
    edge_chk(); chk("post_rst_rdy_state", 16'(o_state), 16'd2);
    chk("post_rst_rdy_signal", o_signal, 16'd0);

    // Randomised command stream
    rnote = 7'd60;
    for (int s = 0; s < 300; s++) begin
      @(negedge clk);
      if ($urandom_range(0, 2) == 0) rnote = 7'($urandom_range(0, 127));
      i_data = {($urandom_range(0, 99) < 80) ? 1'b1 : 1'b0, rnote, 8'($urandom)};
      rst = ($urandom_range(0, 99) < 4) ? 1'b1 : 1'b0;
      if (rst) begin
        @(negedge clk) rst = 1'b0;
      end
      len = int'($urandom_range(1, 30));
      repeat (len) @(negedge clk);
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
